// File: rtl/risc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// risc_ctrl_seq
//   Multi-cycle control sequencer for the SimpleRISC accumulator CPU.
//   Sits between the IR/flag registers and the datapath and produces the
//   PC/IR/ACC load strobes, the ALU function code and the memory strobes.
//   Memory accesses wait on mem_ready. An access that stays stalled too long
//   raises a sticky bus error and parks the sequencer in HALT. Datapath widths
//   live entirely in the datapath, so this block is width-agnostic.
//
// Parameters
//   TIMEOUT   maximum mem_ready-low cycles per access before a bus error;
//             0 disables the timeout entirely
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   opcode     in   4  IR top nibble, valid from DECODE onwards
//   zero       in   1  ACC == 0 flag
//   carry      in   1  registered ALU carry flag
//   mem_ready  in   1  memory completes the current read/write this cycle
//   run        in   1  restart pulse, only honoured in HALT
//   mem_read   out  1  memory read strobe
//   mem_write  out  1  memory write strobe (write data is ACC)
//   addr_sel   out  1  0: PC drives address, 1: IR operand drives address
//   ir_load    out  1  IR <= memory data
//   pc_inc     out  1  PC <= PC + 1
//   pc_load    out  1  PC <= IR operand
//   acc_load   out  1  ACC <= ALU result
//   alu_fn     out  4  ALU function code
//   halted     out  1  high while in HALT
//   bus_err    out  1  sticky access-timeout flag, cleared by run in HALT
// -----------------------------------------------------------------------------
module risc_ctrl_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       carry,
  input  logic       mem_ready,
  input  logic       run,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [3:0] alu_fn,
  output logic       halted,
  output logic       bus_err
);

  // Wait counter width: just wide enough to hold TIMEOUT, never below one bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  // Opcodes
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JMPZ  = 4'd2;
  localparam logic [3:0] OP_JMPNZ = 4'd3;
  localparam logic [3:0] OP_LDA   = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_LSL   = 4'd10;
  localparam logic [3:0] OP_LSR   = 4'd11;
  localparam logic [3:0] OP_LDI   = 4'd12;
  localparam logic [3:0] OP_JMPC  = 4'd13;
  localparam logic [3:0] OP_HALT  = 4'd14;
  localparam logic [3:0] OP_STA   = 4'd15;

  // ALU function codes; the register/immediate codes coincide with the
  // opcode values, so only the pass-through codes need names here.
  localparam logic [3:0] FN_ACC   = 4'd0;
  localparam logic [3:0] FN_MEM   = 4'd4;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          bus_err_reg, bus_err_next;
  logic          timeout_hit;

  // A stalled access gives up only when it is still stalled in the cycle the
  // counter has reached TIMEOUT; a late mem_ready in that cycle still wins.
  assign timeout_hit = TIMEOUT_EN && !mem_ready && (wait_cnt_reg == TIMEOUT_CNT);

  assign bus_err = bus_err_reg;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    bus_err_next  = bus_err_reg;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    addr_sel      = 1'b0;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    acc_load      = 1'b0;
    alu_fn        = FN_ACC;
    halted        = 1'b0;

    unique case (state_reg)
      ST_RST: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          bus_err_next = 1'b1;
          state_next   = ST_HALT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_DECODE: begin
        state_next = ST_FETCH;
        unique case (opcode)
          OP_NOP:   ;
          OP_JMP:   pc_load = 1'b1;
          OP_JMPZ:  pc_load = zero;
          OP_JMPNZ: pc_load = ~zero;
          OP_JMPC:  pc_load = carry;
          OP_NOT, OP_LSL, OP_LSR, OP_LDI: begin
            acc_load = 1'b1;
            alu_fn   = opcode;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = ST_MEMRD;
          OP_STA:   state_next = ST_MEMWR;
          OP_HALT:  state_next = ST_HALT;
          default:  ;
        endcase
      end

      ST_MEMRD: begin
        addr_sel = 1'b1;
        mem_read = 1'b1;
        // LDA passes memory data straight through; the others combine it with ACC.
        alu_fn   = (opcode == OP_LDA) ? FN_MEM : opcode;
        if (mem_ready) begin
          acc_load   = 1'b1;
          state_next = ST_FETCH;
        end else if (timeout_hit) begin
          bus_err_next = 1'b1;
          state_next   = ST_HALT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_MEMWR: begin
        addr_sel  = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_next = ST_FETCH;
        end else if (timeout_hit) begin
          bus_err_next = 1'b1;
          state_next   = ST_HALT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          bus_err_next = 1'b0;
          state_next   = ST_FETCH;
        end
      end

      default: state_next = ST_RST;
    endcase

    // Every access state starts counting from zero, whatever state it came from.
    if (state_next != state_reg) begin
      wait_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RST;
      wait_cnt_reg <= '0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      bus_err_reg  <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_risc_ctrl_seq
//   Instruction-level reference model: each instruction is expanded into the
//   per-cycle output pattern it must produce (fetch access, decode cycle,
//   optional memory access or halt), queued, then replayed against the DUT.
//   A second instance with the timeout disabled shares all inputs.
// -----------------------------------------------------------------------------
module tb_risc_ctrl_seq;

  localparam int TO = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero, carry, mem_ready, run;

  logic       mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load, acc_load, halted, bus_err;
  logic [3:0] alu_fn;
  logic       mem_read_z, mem_write_z, addr_sel_z, ir_load_z, pc_inc_z, pc_load_z, acc_load_z;
  logic       halted_z, bus_err_z;
  logic [3:0] alu_fn_z;

  logic [12:0] obs, obs_z;
  assign obs   = {mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load, acc_load,
                  alu_fn, halted, bus_err};
  assign obs_z = {mem_read_z, mem_write_z, addr_sel_z, ir_load_z, pc_inc_z, pc_load_z,
                  acc_load_z, alu_fn_z, halted_z, bus_err_z};

  risc_ctrl_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .carry(carry),
    .mem_ready(mem_ready), .run(run),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .alu_fn(alu_fn),
    .halted(halted), .bus_err(bus_err)
  );

  risc_ctrl_seq #(.TIMEOUT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .carry(carry),
    .mem_ready(mem_ready), .run(run),
    .mem_read(mem_read_z), .mem_write(mem_write_z), .addr_sel(addr_sel_z),
    .ir_load(ir_load_z), .pc_inc(pc_inc_z), .pc_load(pc_load_z), .acc_load(acc_load_z),
    .alu_fn(alu_fn_z), .halted(halted_z), .bus_err(bus_err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        ready;
    logic        run;
    logic [3:0]  op;
    logic        zero;
    logic        carry;
    logic        last;   // final cycle of an instruction
    logic [12:0] exp;
  } cyc_t;

  cyc_t plan[$];
  logic m_berr;

  function automatic logic [12:0] ov(bit mr, bit mw, bit as_, bit il, bit pi, bit pl, bit al,
                                     logic [3:0] fn, bit h, bit be);
    return {mr, mw, as_, il, pi, pl, al, fn, h, be};
  endfunction

  task automatic push(logic rdy, logic rn, logic [3:0] op, logic z, logic c, logic lst,
                      logic [12:0] e);
    cyc_t x;
    x.ready = rdy; x.run = rn; x.op = op; x.zero = z; x.carry = c; x.last = lst; x.exp = e;
    plan.push_back(x);
  endtask

  // HALT: idle cycles with run low, then the run pulse; bus error clears after it.
  task automatic plan_halt(int idle, logic [3:0] op);
    for (int i = 0; i < idle; i++)
      push(1'($urandom), 1'b0, op, 1'b0, 1'b0, 1'b0, ov(0,0,0,0,0,0,0,4'd0,1,m_berr));
    push(1'($urandom), 1'b1, op, 1'b0, 1'b0, 1'b1, ov(0,0,0,0,0,0,0,4'd0,1,m_berr));
    m_berr = 1'b0;
  endtask

  // kind 0 = instruction fetch, 1 = operand read, 2 = operand write.
  // wt = number of mem_ready-low cycles before it completes.
  task automatic plan_access(int kind, int wt, logic [3:0] op, logic z, logic c,
                             output bit timed_out);
    bit mr, mw, as_;
    logic [3:0] fn;
    mr  = (kind != 2);
    mw  = (kind == 2);
    as_ = (kind != 0);
    fn  = (kind == 1) ? ((op == 4'd4) ? 4'd4 : op) : 4'd0;
    timed_out = 1'b0;
    for (int k = 0; k <= wt; k++) begin
      if (k == wt) begin
        push(1'b1, 1'($urandom), op, z, c, kind != 0,
             ov(mr, mw, as_, kind == 0, kind == 0, 0, kind == 1, fn, 0, m_berr));
        return;
      end
      push(1'b0, 1'($urandom), op, z, c, 1'b0, ov(mr, mw, as_, 0,0,0,0, fn, 0, m_berr));
      if (TO > 0 && k == TO) begin
        m_berr = 1'b1;
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  task automatic plan_instr(logic [3:0] op, logic z, logic c, int wf, int wm);
    bit to;
    bit pl, al;
    logic [3:0] fn;
    plan_access(0, wf, op, z, c, to);
    if (to) begin
      plan_halt($urandom_range(0, 3), op);
      return;
    end
    pl = 0; al = 0; fn = 4'd0;
    case (op)
      4'd1:  pl = 1;
      4'd2:  pl = z;
      4'd3:  pl = !z;
      4'd13: pl = c;
      4'd9, 4'd10, 4'd11, 4'd12: begin al = 1; fn = op; end
      default: ;
    endcase
    push(1'($urandom), 1'($urandom), op, z, c, !(op inside {[4'd4:4'd8], 4'd14, 4'd15}),
         ov(0,0,0,0,0, pl, al, fn, 0, m_berr));
    if (op inside {[4'd4:4'd8]}) begin
      plan_access(1, wm, op, z, c, to);
      if (to) plan_halt($urandom_range(0, 3), op);
    end else if (op == 4'd15) begin
      plan_access(2, wm, op, z, c, to);
      if (to) plan_halt($urandom_range(0, 3), op);
    end else if (op == 4'd14) begin
      plan_halt($urandom_range(0, 3), op);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_berr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc_t e;
    int i = 0;
    mem_ready = 1'b1; run = 1'b0; opcode = 4'd0; zero = 1'b0; carry = 1'b0;
    rst_n = 1'b0; m_berr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 13'd0 || obs_z !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b/%b required all zero", obs, obs_z);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    // After release: one RST cycle, then a NOP stream at zero wait.
    push(1'b1, 1'b0, 4'd0, 0, 0, 1'b0, 13'd0);
    for (int n = 0; n < 4; n++) plan_instr(4'd0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      e = plan.pop_front();
      mem_ready = e.ready; run = e.run; opcode = e.op; zero = e.zero; carry = e.carry;
      @(negedge clk);
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL reset_nop cycle %0d: got %b required %b", i, obs, e.exp);
      end
      if (e.last) $display("txn reset_nop op=%0d done", e.op);
      @(posedge clk); #1; i++;
    end
  endtask

  task automatic test_wait_add();
    cyc_t e;
    int i = 0;
    plan_instr(4'd5, 0, 0, 0, 3);   // ADD, operand read stalls 3 cycles
    plan_instr(4'd4, 0, 0, 2, 1);   // LDA with fetch and read waits
    plan_instr(4'd12, 0, 0, 0, 0);  // LDI
    plan_instr(4'd15, 0, 0, 1, 2);  // STA
    while (plan.size() > 0) begin
      e = plan.pop_front();
      mem_ready = e.ready; run = e.run; opcode = e.op; zero = e.zero; carry = e.carry;
      @(negedge clk);
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL wait_mem cycle %0d op=%0d: got %b required %b", i, e.op, obs, e.exp);
      end
      if (e.last) $display("txn wait_mem op=%0d done", e.op);
      @(posedge clk); #1; i++;
    end
  endtask

  task automatic test_branches();
    cyc_t e;
    int i = 0;
    plan_instr(4'd2, 0, 0, 0, 0);   // JMPZ not taken
    plan_instr(4'd2, 1, 0, 0, 0);   // JMPZ taken
    plan_instr(4'd3, 0, 1, 0, 0);   // JMPNZ taken
    plan_instr(4'd3, 1, 0, 0, 0);   // JMPNZ not taken
    plan_instr(4'd13, 0, 1, 0, 0);  // JMPC taken
    plan_instr(4'd13, 1, 0, 0, 0);  // JMPC not taken
    plan_instr(4'd1, 0, 0, 1, 0);   // JMP
    while (plan.size() > 0) begin
      e = plan.pop_front();
      mem_ready = e.ready; run = e.run; opcode = e.op; zero = e.zero; carry = e.carry;
      @(negedge clk);
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL branch cycle %0d op=%0d z=%0b c=%0b: got %b required %b",
                 i, e.op, e.zero, e.carry, obs, e.exp);
      end
      if (e.last) $display("txn branch op=%0d z=%0b c=%0b done", e.op, e.zero, e.carry);
      @(posedge clk); #1; i++;
    end
  endtask

  task automatic test_timeout();
    cyc_t e;
    int i = 0;
    plan_instr(4'd15, 0, 0, 0, 1000);  // STA never acknowledged -> bus error, HALT, run
    plan_instr(4'd0, 0, 0, TO, 0);     // fetch ready exactly at the limit: completes
    plan_instr(4'd5, 0, 0, 0, TO);     // operand read ready exactly at the limit
    plan_instr(4'd0, 0, 0, TO + 1, 0); // fetch one cycle too slow -> bus error
    plan_instr(4'd14, 0, 0, 0, 0);     // HALT opcode, no bus error
    while (plan.size() > 0) begin
      e = plan.pop_front();
      mem_ready = e.ready; run = e.run; opcode = e.op; zero = e.zero; carry = e.carry;
      @(negedge clk);
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL timeout cycle %0d op=%0d: got %b required %b", i, e.op, obs, e.exp);
      end
      if (e.last) $display("txn timeout op=%0d done", e.op);
      @(posedge clk); #1; i++;
    end
  endtask

  task automatic test_random();
    cyc_t e;
    int i = 0;
    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 19);
      int wf = (r == 0) ? TO + 1 : (r == 1) ? TO : $urandom_range(0, 3);
      int s = $urandom_range(0, 19);
      int wm = (s == 0) ? TO + 1 : (s == 1) ? TO : $urandom_range(0, 3);
      plan_instr(4'($urandom), 1'($urandom), 1'($urandom), wf, wm);
    end
    while (plan.size() > 0) begin
      e = plan.pop_front();
      mem_ready = e.ready; run = e.run; opcode = e.op; zero = e.zero; carry = e.carry;
      @(negedge clk);
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL random cycle %0d op=%0d rdy=%0b: got %b required %b",
                 i, e.op, e.ready, obs, e.exp);
      end
      if (e.last) $display("txn random op=%0d z=%0b c=%0b done", e.op, e.zero, e.carry);
      @(posedge clk); #1; i++;
    end
  endtask

  // Timeout disabled: a fetch stalled for 100 cycles just keeps waiting.
  task automatic test_no_timeout();
    mem_ready = 1'b0; run = 1'b0; opcode = 4'd0;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (obs_z !== 13'd0) begin
      n_fail++;
      $display("FAIL no_timeout_rst: got %b required %b", obs_z, 13'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      run = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs_z !== ov(1,0,0,0,0,0,0,4'd0,0,0)) begin
        n_fail++;
        $display("FAIL no_timeout wait %0d: got %b required %b",
                 k, obs_z, ov(1,0,0,0,0,0,0,4'd0,0,0));
      end
      @(posedge clk); #1;
    end
    $display("txn no_timeout 100 stalled fetch cycles done");
  endtask

  // Reset asserted in the middle of a stalled write drops the strobe at once.
  task automatic test_reset_mid();
    cyc_t e;
    int i = 0;
    do_reset();
    push(1'b0, 1'b0, 4'd15, 0, 0, 1'b0, 13'd0);
    push(1'b1, 1'b0, 4'd15, 0, 0, 1'b0, ov(1,0,0,1,1,0,0,4'd0,0,0));
    push(1'b0, 1'b0, 4'd15, 0, 0, 1'b0, ov(0,0,0,0,0,0,0,4'd0,0,0));
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 4'd15, 0, 0, 1'b0, ov(0,1,1,0,0,0,0,4'd0,0,0));
    while (plan.size() > 0) begin
      e = plan.pop_front();
      mem_ready = e.ready; run = e.run; opcode = e.op; zero = e.zero; carry = e.carry;
      @(negedge clk);
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %b required %b", i, obs, e.exp);
      end
      @(posedge clk); #1; i++;
    end
    mem_ready = 1'b0;
    #2;
    n_checks++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: mem_write got %b required 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b required %b", obs, 13'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1; m_berr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_rst: got %b required %b", obs, 13'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== ov(1,0,0,0,0,0,0,4'd0,0,0)) begin
      n_fail++;
      $display("FAIL reset_mid_fetch: got %b required %b", obs, ov(1,0,0,0,0,0,0,4'd0,0,0));
    end
    $display("txn reset_mid STA abort done");
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'd0; zero = 1'b0; carry = 1'b0; mem_ready = 1'b0; run = 1'b0;
    m_berr = 1'b0;
    test_reset();
    test_wait_add();
    test_branches();
    test_timeout();
    test_random();
    test_no_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
